// File: rtl/piso16_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits, optional parity, stop bit.
// Optional even-parity bit between data and stop is enabled by defining PISO16_PARITY_EN.
module piso16_tx #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV       = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               sout_q, sout_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_div;
`ifdef PISO16_PARITY_EN
    logic               par_q, par_d;
`endif

    // Bit that goes on the line next, taken from the leading end of the shift register.
    function automatic logic head(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
`ifdef PISO16_PARITY_EN
        par_d   = par_q;
`endif
        last_div = (div_q == DIV_W'(DIV - 1));

        // Divider wraps at DIV-1; with DIV=1 it therefore stays at 0.
        if (state_q != S_IDLE) begin
            div_d = last_div ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                sout_d = 1'b1;
                if (valid && ready_q) begin
                    shreg_d = d;
`ifdef PISO16_PARITY_EN
                    par_d   = ^d;
`endif
                    state_d = S_START;
                    sout_d  = 1'b0;
                end
            end
            S_START: begin
                if (last_div) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    sout_d  = head(shreg_q);
                end
            end
            S_DATA: begin
                if (last_div) begin
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
`ifdef PISO16_PARITY_EN
                        state_d = S_PARITY;
                        sout_d  = par_q;
`else
                        state_d = S_STOP;
                        sout_d  = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shift(shreg_q);
                        sout_d  = head(shreg_d);
                    end
                end
            end
`ifdef PISO16_PARITY_EN
            S_PARITY: begin
                if (last_div) begin
                    state_d = S_STOP;
                    sout_d  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (last_div) begin
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (div_d == DIV_W'(DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO16_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PISO16_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready = ready_q;
    assign sout  = sout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_piso16_tx.sv
// Scoreboard bench for piso16_tx: two instances (DIV=1 MSB-first, DIV=4 LSB-first) against a slot-based frame model.
module tb_piso16_tx;

`ifdef PISO16_PARITY_EN
    localparam int NSLOT = 19;
`else
    localparam int NSLOT = 18;
`endif
    localparam int DIV_A = 1;
    localparam int DIV_B = 4;
    localparam bit MSB_A = 1'b1;
    localparam bit MSB_B = 1'b0;
    localparam logic [3:0] IDLE_EXP = 4'b1010;  // {ready,busy,sout,done}

    logic        clk;
    logic        rst;
    logic [15:0] d_a, d_b;
    logic        valid_a, valid_b;
    logic        ready_a, sout_a, busy_a, done_a;
    logic        ready_b, sout_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 1'b0;
    int rem_a = 0;
    int rem_b = 0;
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    piso16_tx #(.WIDTH(16), .DIV(DIV_A), .MSB_FIRST(MSB_A)) dut_a (
        .clk(clk), .rst(rst), .d(d_a), .valid(valid_a),
        .ready(ready_a), .sout(sout_a), .busy(busy_a), .done(done_a)
    );

    piso16_tx #(.WIDTH(16), .DIV(DIV_B), .MSB_FIRST(MSB_B)) dut_b (
        .clk(clk), .rst(rst), .d(d_b), .valid(valid_b),
        .ready(ready_b), .sout(sout_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {ready,busy,sout,done} for cycle idx of a frame, from the slot layout of the frame.
    function automatic logic [3:0] exp_cycle(input logic [15:0] w, input int div, input bit msb, input int idx);
        int  slot;
        logic s;
        slot = idx / div;
        if (slot == 0)
            s = 1'b0;
        else if (slot <= 16)
            s = msb ? w[16 - slot] : w[slot - 1];
`ifdef PISO16_PARITY_EN
        else if (slot == 17)
            s = ^w;
`endif
        else
            s = 1'b1;
        return {1'b0, 1'b1, s, (idx == NSLOT * div - 1)};
    endfunction

    // Reference model: accepts when its own frame countdown is zero.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 1'b1;
            q_a.delete();
            q_b.delete();
            rem_a = 0;
            rem_b = 0;
        end else begin
            if (rem_a == 0) begin
                if (valid_a) begin
                    rem_a = NSLOT * DIV_A;
                    for (int i = 0; i < NSLOT * DIV_A; i++) q_a.push_back(exp_cycle(d_a, DIV_A, MSB_A, i));
                end
            end else rem_a--;
            if (rem_b == 0) begin
                if (valid_b) begin
                    rem_b = NSLOT * DIV_B;
                    for (int i = 0; i < NSLOT * DIV_B; i++) q_b.push_back(exp_cycle(d_b, DIV_B, MSB_B, i));
                end
            end else rem_b--;
        end
    end

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got rbsd=%b want rbsd=%b", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a line state; compare against the scoreboard head or idle.
    always @(negedge clk) begin
        if (started) begin
            logic [3:0] ea, eb;
            ea = (q_a.size() != 0) ? q_a.pop_front() : IDLE_EXP;
            eb = (q_b.size() != 0) ? q_b.pop_front() : IDLE_EXP;
            compare("lane_a", {ready_a, busy_a, sout_a, done_a}, ea);
            compare("lane_b", {ready_b, busy_b, sout_b, done_b}, eb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (rem_a == 0 && rem_b == 0) break;
            tick();
        end
        checks++;
        if (rem_a != 0 || rem_b != 0) begin
            errors++;
            $display("FAIL drain_timeout got rem_a=%0d rem_b=%0d want 0", rem_a, rem_b);
        end
    endtask

    task automatic send_both(input logic [15:0] wa, input logic [15:0] wb);
        valid_a = 1'b1; d_a = wa;
        valid_b = 1'b1; d_b = wb;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        d_a = '0; d_b = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Directed words, including the parity-sensitive pair on lane a.
        send_both(16'hA5C3, 16'h0001);
        repeat (80) tick();
        send_both(16'h0007, 16'h8000);
        drain();
        send_both(16'h0003, 16'hFFFF);
        drain();

        // valid held high with d changing every cycle.
        for (int i = 0; i < 300; i++) begin
            valid_a = 1'b1; valid_b = 1'b1;
            d_a = 16'($urandom);
            d_b = 16'($urandom);
            tick();
        end
        valid_a = 1'b0; valid_b = 1'b0;
        drain();

        // Reset during data bit 7 of lane a, then of lane b, each followed by a clean frame.
        send_both(16'($urandom), 16'($urandom));
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_both(16'($urandom), 16'($urandom));
        repeat (32) tick();
        rst = 1'b1;
        valid_a = 1'b1; valid_b = 1'b1;
        tick();
        rst = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        send_both(16'h1234, 16'hBEEF);
        drain();

        // Sparse random traffic.
        for (int i = 0; i < 300; i++) begin
            valid_a = ($urandom_range(0, 3) == 0);
            valid_b = ($urandom_range(0, 3) == 0);
            d_a = 16'($urandom);
            d_b = 16'($urandom);
            tick();
        end
        valid_a = 1'b0; valid_b = 1'b0;
        drain();
        repeat (5) tick();

        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got a=%0d b=%0d want 0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
